mu2cgra_stream_buffer: RTL and testbench

Elastic buffer between the matrix unit's fused systolic-array output stream (512-bit valid/ready) and the CGRA tile-array input (`mu2cgra`, 32 lanes × 16 bits). Decouples matrix-unit back-pressure from CGRA ready timing with a small FIFO and unpacks each 512-bit beat into per-lane words. Holds an occupancy count for debug, and optionally holds transfer and stall performance counters. Instantiated at the top level in place of the direct `outputsFromSystolicArray_dat` → `mu2cgra` wiring.

---
 rtl/mu2cgra_pkg.sv | 20 ++
 rtl/mu2cgra_fifo.sv | 74 +++++++
 rtl/mu2cgra_stream_buffer.sv | 90 +++++++++
 tb/tb_mu2cgra_stream_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mu2cgra_pkg.sv
// Shared widths, lane/beat types and a saturating-increment helper for the
// matrix-unit to CGRA stream buffer.
package mu2cgra_pkg;

  localparam int unsigned MU2CGRA_NUM_LANES = 32;
  localparam int unsigned MU2CGRA_LANE_W    = 16;
  localparam int unsigned MU2CGRA_BEAT_W    = MU2CGRA_NUM_LANES * MU2CGRA_LANE_W;
  localparam int unsigned MU2CGRA_CNT_W     = 32;

  typedef logic [MU2CGRA_LANE_W-1:0] mu2cgra_lane_t;
  typedef logic [MU2CGRA_BEAT_W-1:0] mu2cgra_beat_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [MU2CGRA_CNT_W-1:0] mu2cgra_sat_inc(
    input logic [MU2CGRA_CNT_W-1:0] v
  );
    return (&v) ? v : v + MU2CGRA_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mu2cgra_fifo.sv
// Valid/ready FIFO: storage array, wrapping pointers, separate occupancy count
// and synchronous flush. Storage is never cleared; only pointers and count are.
module mu2cgra_fifo
  import mu2cgra_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = MU2CGRA_BEAT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [W-1:0]                 wr_dat_i,
  input  logic                         wr_vld_i,
  output logic                         wr_rdy_o,
  output logic [W-1:0]                 rd_dat_o,
  output logic                         rd_vld_o,
  input  logic                         rd_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Flags depend only on registered count and flush, never on rd_rdy_i.
  assign wr_rdy_o = (count_q != CW'(DEPTH)) && !flush_i;
  assign rd_vld_o = (count_q != CW'(0));
  assign push     = wr_vld_i && wr_rdy_o;
  assign pop      = rd_vld_o && rd_rdy_i;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array has no reset so it maps onto plain storage.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/mu2cgra_stream_buffer.sv
// Elastic buffer from the matrix-unit output stream to the CGRA lane inputs.
// Optional transfer/stall perf counters are built when MU2CGRA_PERF_CNT_EN is defined.
module mu2cgra_stream_buffer
  import mu2cgra_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_LANES = MU2CGRA_NUM_LANES,
  parameter int unsigned LANE_W    = MU2CGRA_LANE_W
) (
  input  logic                             clk_in,
  input  logic                             reset_in_n,
  input  logic                             flush,
  input  logic [NUM_LANES*LANE_W-1:0]      mu_dat,
  input  logic                             mu_vld,
  output logic                             mu_rdy,
  output logic [LANE_W-1:0]                mu2cgra [NUM_LANES],
  output logic                             mu2cgra_valid,
  input  logic                             cgra2mu_ready,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
`ifdef MU2CGRA_PERF_CNT_EN
  ,
  input  logic                             perf_clear,
  output logic [MU2CGRA_CNT_W-1:0]         xfer_count,
  output logic [MU2CGRA_CNT_W-1:0]         stall_count
`endif
);

  localparam int unsigned BW = NUM_LANES * LANE_W;

  logic [BW-1:0] head;

  mu2cgra_fifo #(
    .DEPTH (DEPTH),
    .W     (BW)
  ) u_fifo (
    .clk_i    (clk_in),
    .rst_ni   (reset_in_n),
    .flush_i  (flush),
    .wr_dat_i (mu_dat),
    .wr_vld_i (mu_vld),
    .wr_rdy_o (mu_rdy),
    .rd_dat_o (head),
    .rd_vld_o (mu2cgra_valid),
    .rd_rdy_i (cgra2mu_ready),
    .count_o  (occupancy)
  );

  // Lane 0 takes the least significant slice of the head beat.
  always_comb begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      mu2cgra[i] = head[i*LANE_W +: LANE_W];
    end
  end

`ifdef MU2CGRA_PERF_CNT_EN
  logic [MU2CGRA_CNT_W-1:0] xfer_q, xfer_d;
  logic [MU2CGRA_CNT_W-1:0] stall_q, stall_d;
  logic                     pop, stall;

  // A pop during flush still counts as a transfer.
  assign pop   = mu2cgra_valid && cgra2mu_ready;
  assign stall = mu2cgra_valid && !cgra2mu_ready;

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (perf_clear) begin
      xfer_d  = '0;
      stall_d = '0;
    end else begin
      if (pop)   xfer_d  = mu2cgra_sat_inc(xfer_q);
      if (stall) stall_d = mu2cgra_sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end

  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mu2cgra_stream_buffer.sv
// Scoreboard bench for mu2cgra_stream_buffer: a queue-based reference model is
// updated on each rising edge and compared against the DUT on each falling edge.
module tb_mu2cgra_stream_buffer;
  import mu2cgra_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NL    = 32;
  localparam int unsigned LW    = 16;
  localparam int unsigned BW    = NL * LW;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk_in        = 1'b0;
  logic          reset_in_n    = 1'b1;
  logic          flush         = 1'b0;
  logic [BW-1:0] mu_dat        = '0;
  logic          mu_vld        = 1'b0;
  logic          cgra2mu_ready = 1'b0;
  logic          mu_rdy;
  logic          mu2cgra_valid;
  logic [LW-1:0] mu2cgra [NL];
  logic [CW-1:0] occupancy;
`ifdef MU2CGRA_PERF_CNT_EN
  logic          perf_clear = 1'b0;
  logic [31:0]   xfer_count, stall_count;
`endif

  int            checks   = 0;
  int            failures = 0;
  logic [BW-1:0] mdl [$];
  logic [31:0]   m_xfer   = '0;
  logic [31:0]   m_stall  = '0;
  bit            m_valid, m_rdy, m_push, m_pop;
  logic [BW-1:0] head;

  mu2cgra_stream_buffer #(.DEPTH(DEPTH), .NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk_in        (clk_in),
    .reset_in_n    (reset_in_n),
    .flush         (flush),
    .mu_dat        (mu_dat),
    .mu_vld        (mu_vld),
    .mu_rdy        (mu_rdy),
    .mu2cgra       (mu2cgra),
    .mu2cgra_valid (mu2cgra_valid),
    .cgra2mu_ready (cgra2mu_ready),
    .occupancy     (occupancy)
`ifdef MU2CGRA_PERF_CNT_EN
    ,
    .perf_clear    (perf_clear),
    .xfer_count    (xfer_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Lane k of beat n carries {n[7:0], k[7:0]}.
  function automatic logic [BW-1:0] beat_of(int n);
    logic [BW-1:0] b;
    for (int k = 0; k < int'(NL); k++) b[k*LW +: LW] = LW'((n & 8'hFF) * 256 + k);
    return b;
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] b;
    for (int k = 0; k < int'(NL); k++) b[k*LW +: LW] = LW'($urandom);
    return b;
  endfunction

  // Reference model: a bounded queue plus counters.
  always @(posedge clk_in) begin
    if (reset_in_n) begin
      m_valid = mdl.size() != 0;
      m_rdy   = (mdl.size() != DEPTH) && !flush;
      m_pop   = m_valid && cgra2mu_ready;
      m_push  = mu_vld && m_rdy;
`ifdef MU2CGRA_PERF_CNT_EN
      if (perf_clear) begin
        m_xfer  = '0;
        m_stall = '0;
      end else begin
        if (m_pop && m_xfer != 32'hFFFF_FFFF) m_xfer++;
        if (m_valid && !cgra2mu_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      end
`endif
      if (flush) mdl.delete();
      else begin
        if (m_pop)  void'(mdl.pop_front());
        if (m_push) mdl.push_back(mu_dat);
      end
    end
  end

  // Monitor: compare flags, count and head beat against the model.
  always @(negedge clk_in) begin
    chk("occupancy", BW'(occupancy), BW'(mdl.size()));
    chk("mu2cgra_valid", BW'(mu2cgra_valid), BW'(mdl.size() != 0));
    chk("mu_rdy", BW'(mu_rdy), BW'((mdl.size() != DEPTH) && !flush));
    if (mu2cgra_valid && mdl.size() != 0) begin
      for (int i = 0; i < int'(NL); i++) head[i*LW +: LW] = mu2cgra[i];
      chk("head_beat", head, mdl[0]);
    end
`ifdef MU2CGRA_PERF_CNT_EN
    chk("xfer_count", BW'(xfer_count), BW'(m_xfer));
    chk("stall_count", BW'(stall_count), BW'(m_stall));
`endif
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic assert_reset();
    reset_in_n = 1'b0;
    mdl.delete();
    m_xfer  = '0;
    m_stall = '0;
  endtask

  initial begin
    int pops;
    bit acc;

    // Reset
    #1 assert_reset();
    #1;
    chk("rst_occupancy", BW'(occupancy), '0);
    chk("rst_valid", BW'(mu2cgra_valid), '0);
    chk("rst_rdy", BW'(mu_rdy), BW'(1));
    repeat (2) step();
    reset_in_n = 1'b1;

    // Single beat
    mu_dat = beat_of(0); mu_vld = 1'b1;
    step();
    mu_vld = 1'b0;
    chk("single_valid", BW'(mu2cgra_valid), BW'(1));
    chk("single_lane5", BW'(mu2cgra[5]), BW'(16'h0005));
    cgra2mu_ready = 1'b1;
    step();
    cgra2mu_ready = 1'b0;
    chk("single_occ_after_pop", BW'(occupancy), '0);

    // Fill with ready low
    for (int n = 1; n <= 4; n++) begin
      mu_dat = beat_of(n); mu_vld = 1'b1;
      step();
    end
    mu_dat = beat_of(5);
    chk("fill_rdy_low", BW'(mu_rdy), '0);
    chk("fill_occ", BW'(occupancy), BW'(DEPTH));
    cgra2mu_ready = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) begin
      @(negedge clk_in);
      acc = mu_vld && mu_rdy;
      step();
    end
    chk("fill_5th_accepted", BW'(acc), BW'(1));
    mu_vld = 1'b0;
    for (int t = 0; t < 20 && mu2cgra_valid; t++) step();
    chk("fill_drained", BW'(mu2cgra_valid), '0);
    cgra2mu_ready = 1'b0;

    // Streaming at full rate
    pops = 0;
    mu_vld = 1'b1; cgra2mu_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mu_dat = beat_of(i);
      if (mu2cgra_valid) pops++;
      step();
    end
    mu_vld = 1'b0;
    chk("stream_pops", BW'(pops), BW'(99));
    chk("stream_occ", BW'(occupancy), BW'(1));
    step();
    cgra2mu_ready = 1'b0;

    // Flush with a pop in the same cycle
    for (int n = 10; n < 13; n++) begin
      mu_dat = beat_of(n); mu_vld = 1'b1;
      step();
    end
    mu_vld = 1'b0;
    flush = 1'b1; cgra2mu_ready = 1'b1;
    #1 chk("flush_rdy_low", BW'(mu_rdy), '0);
    step();
    flush = 1'b0; cgra2mu_ready = 1'b0;
    chk("flush_occ", BW'(occupancy), '0);
    chk("flush_valid", BW'(mu2cgra_valid), '0);

    // Asynchronous reset between edges
    for (int n = 20; n < 22; n++) begin
      mu_dat = beat_of(n); mu_vld = 1'b1;
      step();
    end
    mu_vld = 1'b0;
    #2 assert_reset();
    #1;
    chk("arst_occupancy", BW'(occupancy), '0);
    chk("arst_valid", BW'(mu2cgra_valid), '0);
    chk("arst_rdy", BW'(mu_rdy), BW'(1));
`ifdef MU2CGRA_PERF_CNT_EN
    chk("arst_xfer", BW'(xfer_count), '0);
    chk("arst_stall", BW'(stall_count), '0);
`endif
    step();
    reset_in_n = 1'b1;

    // 10 pops followed by 7 stalled cycles
    mu_vld = 1'b1; cgra2mu_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mu_dat = beat_of(40 + i);
      step();
    end
    mu_vld = 1'b0; cgra2mu_ready = 1'b0;
    repeat (7) step();
`ifdef MU2CGRA_PERF_CNT_EN
    chk("perf_xfer10", BW'(xfer_count), BW'(10));
    chk("perf_stall7", BW'(stall_count), BW'(7));
    perf_clear = 1'b1; cgra2mu_ready = 1'b1;
    step();
    perf_clear = 1'b0; cgra2mu_ready = 1'b0;
    chk("perf_clear_xfer", BW'(xfer_count), '0);
    chk("perf_clear_stall", BW'(stall_count), '0);
`else
    chk("perf_seq_occ", BW'(occupancy), BW'(1));
    cgra2mu_ready = 1'b1;
    step();
    cgra2mu_ready = 1'b0;
`endif

    // Randomized traffic
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!mu_vld || acc) begin
        mu_vld = ($urandom_range(0, 99) < 70);
        mu_dat = rnd_beat();
      end
      cgra2mu_ready = ($urandom_range(0, 99) < 60);
      flush         = ($urandom_range(0, 99) < 3);
`ifdef MU2CGRA_PERF_CNT_EN
      perf_clear    = ($urandom_range(0, 99) < 2);
`endif
      @(negedge clk_in);
      acc = mu_vld && mu_rdy;
      step();
    end
    mu_vld = 1'b0; flush = 1'b0; cgra2mu_ready = 1'b1;
`ifdef MU2CGRA_PERF_CNT_EN
    perf_clear = 1'b0;
`endif
    for (int t = 0; t < 20 && mu2cgra_valid; t++) step();
    chk("final_empty", BW'(occupancy), '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
